aes_axil_slave: RTL and testbench
=================================

# aes_axil_slave

AXI4-Lite slave register front-end for the AES core. It takes key, data and command writes from the PicoRV32 AXI4-Lite master and sequences the core's plaintext and ciphertext handshakes. It captures the core's result, exposes status and result registers for the CPU to read, and replaces the directed stimulus process used at the core boundary.

## Interface
- ADDR_W, 8, AXI address width; bits [ADDR_W-1:7] must be 0 for any register hit.
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel; wstrb is ignored and full words are written.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- pt_valid, ct_valid  out  1  one-cycle launch strobes to the core.
- pt_in_en, ct_in_en  in  1  core ready to accept plaintext or ciphertext.
- pt_encr, ct_decr  out  128  data to the core; both are driven from DIN.
- ct_encr, pt_decr  in  128  core results.
- ct_rdy, pt_rdy  in  1  core result valid.
- key_len  out  2  key-length code; non-zero only in the launch cycle.
- short_key  out  256  key words, left-aligned.
- key_exp_status, key_inp_rdy, error  in  1  core status.

## Operation
Register map (byte addresses):
- 0x00 CTRL (write-only; reads return 0):
  - bit0 start encrypt; bit1 start decrypt (encrypt wins if both set).
  - bits3:2 key length code.
  - bit4 load new key.
  - bit5 clear the sticky error.
- 0x04 STATUS (read-only): bit0 busy, bit1 done, bit2 error (sticky), bit3 key_exp_status, bit4 key_inp_rdy.
- 0x10–0x2C KEY0..7 (read/write). KEY0 maps to short_key[255:224].
- 0x30–0x3C DIN0..3 (read/write). DIN0 maps to bits [127:96].
- 0x40–0x4C DOUT0..3 (read-only). DOUT0 maps to bits [127:96].
- Any other address: reads return 0 with resp SLVERR (2'b10); writes are dropped with SLVERR. Mapped accesses return OKAY. A write to STATUS or DOUT is dropped with OKAY.

Sequencer FSM, states IDLE → WAIT_EN → LAUNCH → WAIT_RDY → IDLE:
- IDLE: a CTRL write with bit0 or bit1 set latches the direction, the key-length code and the load-new-key flag. It sets busy=1, clears done and moves to WAIT_EN.
- WAIT_EN: waits for the selected pt_in_en (encrypt) or ct_in_en (decrypt).
- LAUNCH: drives the selected valid high for exactly one cycle. key_len = latched code if load-new-key is set, otherwise 2'b00.
- WAIT_RDY: waits for ct_rdy (encrypt) or pt_rdy (decrypt). On that cycle it copies ct_encr or pt_decr into DOUT, sets done=1, clears busy and returns to IDLE.
- Core error high in WAIT_EN or WAIT_RDY: abort to IDLE, set the sticky error bit, leave done=0 and leave DOUT unchanged.
- Sticky error is cleared by a CTRL write with bit5 set. If clear and a new error arrive in the same cycle, the set wins.
- While busy, writes to CTRL start bits, KEY and DIN are ignored but still get an OKAY response. CTRL bit5 still takes effect while busy.
- pt_encr, ct_decr and short_key are driven continuously from the DIN and KEY registers.

## Timing
- Reset values: all ready and valid outputs 0; bresp and rresp 0; rdata 0; pt_valid and ct_valid 0; key_len 0; all registers 0; FSM in IDLE.
- Reset has immediate effect, including mid-transfer or mid-operation. Any AXI transaction in flight is discarded.
- Write channel:
  - awready and wready rise together for one cycle only when awvalid and wvalid are both high, no response is pending and reset is deasserted.
  - The register update happens on that handshake edge.
  - bvalid rises the next cycle and holds until bready; no new write is accepted meanwhile.
- Read channel:
  - arready is high when no read response is pending.
  - rvalid and rdata appear the cycle after the address handshake and hold stable until rready.
- Read and write channels are independent. A read of the register written in the same cycle returns the old value.
- Start write to LAUNCH: minimum 2 cycles (if the enable is already high, WAIT_EN lasts 1 cycle).
- Result capture to a STATUS read showing done: same edge, so a read issued on the next cycle sees done=1.

## Test plan
- Encrypt: write KEY0..3 = 2b7e1516,28aed2a6,abf71588,09cf4f3c and KEY4..7=0; write DIN = 3243f6a8885a308d313198a2e0370734; write CTRL=0x1D. Required: the next STATUS read after done reads 0x2 plus the key bits, and DOUT = 3925841d02dc09fbdc118597196a0b32.
- Decrypt: with the same key, DIN = 3925841d…0b32 and CTRL=0x02. Required: DOUT = 3243f6a8…0734 and key_len = 0 during the launch cycle.
- Busy lockout: during WAIT_RDY, write DIN0=0xFFFFFFFF and CTRL=0x01. Required: OKAY responses, DIN0 unchanged, exactly one pt_valid pulse.
- Protocol: read 0x7C → rdata 0, rresp 2'b10. Hold bready low for 5 cycles → bvalid and bresp stay stable, and a second write waits.
- Error: force core error in WAIT_RDY. Required: STATUS = 0x4 and the FSM in IDLE. A CTRL write of 0x20 then gives STATUS bit2 = 0.
- Reset mid-operation: drop reset in WAIT_EN. Required: all outputs at reset values asynchronously, and after release STATUS reads 0.

Source files
------------

// File: rtl/aes_axil_slave_if.sv
// AXI4-Lite bus bundle between the PicoRV32 master and the AES register front-end.
interface aes_axil_slave_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/aes_axil_slave.sv
// AXI4-Lite register front-end for the AES core: key/data/command registers,
// a four-state sequencer for the core's launch and result handshakes, and
// status/result registers for the CPU.
module aes_axil_slave #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    aes_axil_slave_if.slave s_axi,
    output logic            pt_valid,
    output logic            ct_valid,
    input  logic            pt_in_en,
    input  logic            ct_in_en,
    output logic [127:0]    pt_encr,
    output logic [127:0]    ct_decr,
    input  logic [127:0]    ct_encr,
    input  logic [127:0]    pt_decr,
    input  logic            ct_rdy,
    input  logic            pt_rdy,
    output logic [1:0]      key_len,
    output logic [255:0]    short_key,
    input  logic            key_exp_status,
    input  logic            key_inp_rdy,
    input  logic            error
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        R_CTRL,
        R_STATUS,
        R_KEY,
        R_DIN,
        R_DOUT,
        R_NONE
    } reg_sel_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_EN,
        S_LAUNCH,
        S_WAIT_RDY
    } state_t;

    // Map a byte address to a register group; anything outside the map
    // (including any set bit above bit 6) is R_NONE.
    function automatic reg_sel_t decode(input logic [ADDR_W-1:0] addr);
        reg_sel_t   sel;
        logic [4:0] widx;
        widx = addr[6:2];
        sel  = R_NONE;
        if (addr[ADDR_W-1:7] == '0) begin
            if (widx == 5'd0)                         sel = R_CTRL;
            else if (widx == 5'd1)                    sel = R_STATUS;
            else if (widx >= 5'd4  && widx <= 5'd11)  sel = R_KEY;
            else if (widx >= 5'd12 && widx <= 5'd15)  sel = R_DIN;
            else if (widx >= 5'd16 && widx <= 5'd19)  sel = R_DOUT;
        end
        return sel;
    endfunction

    // Register storage
    logic [31:0] key_reg  [8];
    logic [31:0] din_reg  [4];
    logic [31:0] dout_reg [4];

    // AXI channel state
    logic        awready_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;
    logic        arready_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;

    // Sequencer state
    state_t      state_reg;
    logic        dir_dec_reg;
    logic [1:0]  klen_reg;
    logic        load_key_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic        pt_valid_reg;
    logic        ct_valid_reg;
    logic [1:0]  key_len_reg;

    // Write strobes are not supported: every write is a full word.
    logic unused_wstrb;
    assign unused_wstrb = ^s_axi.wstrb;

    // Decode of both channels
    reg_sel_t    wr_sel;
    reg_sel_t    rd_sel;
    logic        wr_hs;
    logic        rd_hs;
    logic        ctrl_wr;
    logic        start_req;
    logic        err_clr;
    logic [2:0]  wr_key_idx;
    logic [2:0]  rd_key_idx;
    logic [127:0] core_result;
    logic [31:0] rd_value;

    assign wr_sel    = decode(s_axi.awaddr);
    assign rd_sel    = decode(s_axi.araddr);
    assign wr_hs     = awready_reg && s_axi.awvalid && s_axi.wvalid;
    assign rd_hs     = arready_reg && s_axi.arvalid;
    assign ctrl_wr   = wr_hs && (wr_sel == R_CTRL);
    assign start_req = ctrl_wr && (s_axi.wdata[0] || s_axi.wdata[1]);
    assign err_clr   = ctrl_wr && s_axi.wdata[5];

    // KEY0..7 sit at word indices 4..11; flipping bit 2 of the word index
    // turns that range into 0..7 without a subtractor.
    assign wr_key_idx = s_axi.awaddr[4:2] ^ 3'b100;
    assign rd_key_idx = s_axi.araddr[4:2] ^ 3'b100;

    assign core_result = dir_dec_reg ? pt_decr : ct_encr;

    // Word 0 of each block is the most significant 32 bits of the bus.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key
            assign short_key[255 - 32*gi -: 32] = key_reg[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_din
            assign pt_encr[127 - 32*gi -: 32] = din_reg[gi];
            assign ct_decr[127 - 32*gi -: 32] = din_reg[gi];
        end
    endgenerate

    assign s_axi.awready = awready_reg;
    assign s_axi.wready  = awready_reg;
    assign s_axi.bvalid  = bvalid_reg;
    assign s_axi.bresp   = bresp_reg;
    assign s_axi.arready = arready_reg;
    assign s_axi.rvalid  = rvalid_reg;
    assign s_axi.rdata   = rdata_reg;
    assign s_axi.rresp   = rresp_reg;
    assign pt_valid      = pt_valid_reg;
    assign ct_valid      = ct_valid_reg;
    assign key_len       = key_len_reg;

    // Write channel: one-cycle joint awready/wready pulse, then hold bvalid until bready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            awready_reg <= 1'b0;
            if (wr_hs) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= (wr_sel == R_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_reg && s_axi.bready) begin
                bvalid_reg <= 1'b0;
            end else if (!bvalid_reg && !awready_reg && s_axi.awvalid && s_axi.wvalid) begin
                awready_reg <= 1'b1;
            end
        end
    end

    // KEY and DIN registers: CPU writes land only while the sequencer is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) key_reg[i] <= '0;
            for (int i = 0; i < 4; i++) din_reg[i] <= '0;
        end else if (wr_hs && !busy_reg) begin
            if (wr_sel == R_KEY) key_reg[wr_key_idx] <= s_axi.wdata;
            if (wr_sel == R_DIN) din_reg[s_axi.awaddr[3:2]] <= s_axi.wdata;
        end
    end

    // Read data mux; STATUS samples the core status inputs live.
    always_comb begin
        rd_value = '0;
        case (rd_sel)
            R_STATUS: rd_value = {27'd0, key_inp_rdy, key_exp_status, err_reg, done_reg, busy_reg};
            R_KEY:    rd_value = key_reg[rd_key_idx];
            R_DIN:    rd_value = din_reg[s_axi.araddr[3:2]];
            R_DOUT:   rd_value = dout_reg[s_axi.araddr[3:2]];
            default:  rd_value = '0;
        endcase
    end

    // Read channel: arready whenever no response is pending; rdata held until rready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else if (rd_hs) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rdata_reg   <= rd_value;
            rresp_reg   <= (rd_sel == R_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_reg && s_axi.rready) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
        end else if (!rvalid_reg) begin
            arready_reg <= 1'b1;
        end
    end

    // Sequencer: start -> wait for core enable -> one-cycle launch -> wait for result.
    // A core error in either wait state aborts and sets the sticky error; a
    // same-cycle clear loses to the set because the set is assigned last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            dir_dec_reg  <= 1'b0;
            klen_reg     <= 2'b00;
            load_key_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            pt_valid_reg <= 1'b0;
            ct_valid_reg <= 1'b0;
            key_len_reg  <= 2'b00;
            for (int i = 0; i < 4; i++) dout_reg[i] <= '0;
        end else begin
            pt_valid_reg <= 1'b0;
            ct_valid_reg <= 1'b0;
            key_len_reg  <= 2'b00;
            if (err_clr) err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_req) begin
                        dir_dec_reg  <= !s_axi.wdata[0];
                        klen_reg     <= s_axi.wdata[3:2];
                        load_key_reg <= s_axi.wdata[4];
                        busy_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                        state_reg    <= S_WAIT_EN;
                    end
                end
                S_WAIT_EN: begin
                    if (error) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (dir_dec_reg ? ct_in_en : pt_in_en) begin
                        pt_valid_reg <= !dir_dec_reg;
                        ct_valid_reg <= dir_dec_reg;
                        key_len_reg  <= load_key_reg ? klen_reg : 2'b00;
                        state_reg    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_reg <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (error) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (dir_dec_reg ? pt_rdy : ct_rdy) begin
                        for (int i = 0; i < 4; i++) dout_reg[i] <= core_result[127 - 32*i -: 32];
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_axil_slave.sv
// Bench for aes_axil_slave: register-map vector table plus directed sequences
// for encrypt, decrypt, busy lockout, write back-pressure, error and reset.
module tb_aes_axil_slave;

    localparam logic [127:0] PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_axil_slave_if #(.ADDR_W(8)) s_axi ();

    logic         pt_valid;
    logic         ct_valid;
    logic         pt_in_en;
    logic         ct_in_en;
    logic [127:0] pt_encr;
    logic [127:0] ct_decr;
    logic [127:0] ct_encr = '0;
    logic [127:0] pt_decr = '0;
    logic         ct_rdy = 1'b0;
    logic         pt_rdy = 1'b0;
    logic [1:0]   key_len;
    logic [255:0] short_key;
    logic         key_exp_status;
    logic         key_inp_rdy;
    logic         core_err = 1'b0;

    aes_axil_slave #(.ADDR_W(8)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .s_axi          (s_axi),
        .pt_valid       (pt_valid),
        .ct_valid       (ct_valid),
        .pt_in_en       (pt_in_en),
        .ct_in_en       (ct_in_en),
        .pt_encr        (pt_encr),
        .ct_decr        (ct_decr),
        .ct_encr        (ct_encr),
        .pt_decr        (pt_decr),
        .ct_rdy         (ct_rdy),
        .pt_rdy         (pt_rdy),
        .key_len        (key_len),
        .short_key      (short_key),
        .key_exp_status (key_exp_status),
        .key_inp_rdy    (key_inp_rdy),
        .error          (core_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Core stand-in state
    int         pt_pulses = 0;
    int         ct_pulses = 0;
    logic [1:0] launch_klen = 2'b11;
    int         resp_delay = 3;
    logic       inject_err = 1'b0;
    logic       pend = 1'b0;
    logic       pend_dec = 1'b0;
    int         cnt = 0;

    // Core stand-in: counts launch strobes, then after resp_delay cycles
    // returns the known AES vector (or an error pulse when inject_err is set).
    always @(negedge clk) begin
        ct_rdy   = 1'b0;
        pt_rdy   = 1'b0;
        core_err = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (pt_valid || ct_valid) begin
            if (pt_valid) pt_pulses++;
            if (ct_valid) ct_pulses++;
            launch_klen = key_len;
            pend        = 1'b1;
            pend_dec    = ct_valid;
            cnt         = resp_delay;
        end else if (pend) begin
            if (cnt > 0) begin
                cnt--;
            end else begin
                pend = 1'b0;
                if (inject_err) begin
                    core_err = 1'b1;
                end else if (pend_dec) begin
                    pt_decr = (ct_decr == CT) ? PT : ~ct_decr;
                    pt_rdy  = 1'b1;
                end else begin
                    ct_encr = (pt_encr == PT) ? CT : ~pt_encr;
                    ct_rdy  = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        s_axi.awaddr  = a;
        s_axi.wdata   = d;
        s_axi.wstrb   = 4'hF;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        s_axi.bready  = 1'b1;
        n = 0;
        while (!s_axi.awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            fail_timeout("awready_wait");
            s_axi.awvalid = 1'b0;
            s_axi.wvalid  = 1'b0;
            resp = 2'b11;
            return;
        end
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axi.bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            fail_timeout("bvalid_wait");
            resp = 2'b11;
            return;
        end
        resp = s_axi.bresp;
        @(posedge clk); #1;
        s_axi.bready = 1'b0;
        $display("wr addr=%02h data=%08h bresp=%0d", a, d, resp);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        s_axi.araddr  = a;
        s_axi.arvalid = 1'b1;
        s_axi.rready  = 1'b1;
        n = 0;
        while (!s_axi.arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            fail_timeout("arready_wait");
            s_axi.arvalid = 1'b0;
            d = 'x;
            resp = 2'b11;
            return;
        end
        @(posedge clk); #1;
        s_axi.arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axi.rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            fail_timeout("rvalid_wait");
            d = 'x;
            resp = 2'b11;
            return;
        end
        d    = s_axi.rdata;
        resp = s_axi.rresp;
        @(posedge clk); #1;
        s_axi.rready = 1'b0;
        $display("rd addr=%02h data=%08h rresp=%0d", a, d, resp);
    endtask

    // Poll STATUS until busy clears; returns the first non-busy value.
    task automatic wait_idle(output logic [31:0] st);
        logic [1:0] r;
        int n;
        n  = 0;
        st = 32'h1;
        while (st[0] && n < 100) begin axi_read(8'h04, st, r); n++; end
        if (st[0]) fail_timeout("wait_idle");
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    function automatic vec_t mkw(logic [7:0] a, logic [31:0] d, logic [1:0] rsp);
        vec_t v;
        v.wr = 1'b1; v.addr = a; v.data = d; v.exp_data = '0; v.exp_resp = rsp;
        return v;
    endfunction

    function automatic vec_t mkr(logic [7:0] a, logic [31:0] e, logic [1:0] rsp);
        vec_t v;
        v.wr = 1'b0; v.addr = a; v.data = '0; v.exp_data = e; v.exp_resp = rsp;
        return v;
    endfunction

    localparam int NV = 26;
    vec_t vecs [NV];

    initial begin
        logic [31:0] d;
        logic [31:0] st;
        logic [1:0]  r;
        int          p0;
        int          n;

        s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
        s_axi.wvalid = 1'b0; s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
        pt_in_en = 1'b1; ct_in_en = 1'b1; key_exp_status = 1'b0; key_inp_rdy = 1'b0;

        vecs[0]  = mkw(8'h10, 32'h2b7e1516, 2'b00);
        vecs[1]  = mkw(8'h14, 32'h28aed2a6, 2'b00);
        vecs[2]  = mkw(8'h18, 32'habf71588, 2'b00);
        vecs[3]  = mkw(8'h1C, 32'h09cf4f3c, 2'b00);
        vecs[4]  = mkw(8'h20, 32'h00000000, 2'b00);
        vecs[5]  = mkw(8'h24, 32'h00000000, 2'b00);
        vecs[6]  = mkw(8'h28, 32'h00000000, 2'b00);
        vecs[7]  = mkw(8'h2C, 32'h00000000, 2'b00);
        vecs[8]  = mkw(8'h30, 32'h3243f6a8, 2'b00);
        vecs[9]  = mkw(8'h34, 32'h885a308d, 2'b00);
        vecs[10] = mkw(8'h38, 32'h313198a2, 2'b00);
        vecs[11] = mkw(8'h3C, 32'he0370734, 2'b00);
        vecs[12] = mkr(8'h10, 32'h2b7e1516, 2'b00);
        vecs[13] = mkr(8'h1C, 32'h09cf4f3c, 2'b00);
        vecs[14] = mkr(8'h3C, 32'he0370734, 2'b00);
        vecs[15] = mkr(8'h00, 32'h00000000, 2'b00);
        vecs[16] = mkr(8'h04, 32'h00000000, 2'b00);
        vecs[17] = mkr(8'h7C, 32'h00000000, 2'b10);
        vecs[18] = mkr(8'h08, 32'h00000000, 2'b10);
        vecs[19] = mkw(8'h7C, 32'hdeadbeef, 2'b10);
        vecs[20] = mkw(8'h04, 32'hffffffff, 2'b00);
        vecs[21] = mkr(8'h04, 32'h00000000, 2'b00);
        vecs[22] = mkr(8'h40, 32'h00000000, 2'b00);
        vecs[23] = mkw(8'h40, 32'h00000001, 2'b00);
        vecs[24] = mkr(8'h40, 32'h00000000, 2'b00);
        vecs[25] = mkr(8'h90, 32'h00000000, 2'b10);

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("reset_axi", {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bresp,
                            s_axi.arready, s_axi.rvalid, s_axi.rresp, s_axi.rdata}, '0);
        check("reset_core", {pt_valid, ct_valid, key_len, short_key[31:0], pt_encr[31:0]}, '0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arready_idle", s_axi.arready, 1'b1);

        // Register map table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, r);
                check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
            end
        end
        check("short_key", short_key, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});

        // Encrypt with new 128-bit key load
        key_inp_rdy = 1'b1;
        axi_write(8'h00, 32'h1D, r);
        wait_idle(st);
        check("enc_status", st, 32'h12);
        check("enc_klen", launch_klen, 2'b11);
        check("enc_pulses", pt_pulses, 1);
        for (int i = 0; i < 4; i++) begin
            axi_read(8'h40 + 8'(4*i), d, r);
            check($sformatf("enc_dout%0d", i), d, CT[127 - 32*i -: 32]);
        end

        // Decrypt with the same key, no key reload
        for (int i = 0; i < 4; i++) axi_write(8'h30 + 8'(4*i), CT[127 - 32*i -: 32], r);
        axi_write(8'h00, 32'h02, r);
        wait_idle(st);
        check("dec_status", st, 32'h12);
        check("dec_klen", launch_klen, 2'b00);
        check("dec_pulses", ct_pulses, 1);
        for (int i = 0; i < 4; i++) begin
            axi_read(8'h40 + 8'(4*i), d, r);
            check($sformatf("dec_dout%0d", i), d, PT[127 - 32*i -: 32]);
        end

        // Busy lockout during WAIT_RDY
        for (int i = 0; i < 4; i++) axi_write(8'h30 + 8'(4*i), PT[127 - 32*i -: 32], r);
        resp_delay = 60;
        p0 = pt_pulses;
        axi_write(8'h00, 32'h01, r);
        n = 0;
        while (pt_pulses == p0 && n < 50) begin @(negedge clk); n++; end
        if (pt_pulses == p0) fail_timeout("lock_launch");
        axi_write(8'h30, 32'hffffffff, r);
        check("lock_din_bresp", r, 2'b00);
        axi_write(8'h00, 32'h01, r);
        check("lock_ctrl_bresp", r, 2'b00);
        axi_read(8'h04, d, r);
        check("lock_status_busy", d, 32'h11);
        wait_idle(st);
        check("lock_status_done", st, 32'h12);
        repeat (10) @(negedge clk);
        check("lock_pulses", pt_pulses, p0 + 1);
        axi_read(8'h30, d, r);
        check("lock_din0", d, 32'h3243f6a8);
        axi_read(8'h40, d, r);
        check("lock_dout0", d, 32'h3925841d);
        resp_delay = 3;

        // Write response back-pressure with a second write waiting
        @(negedge clk);
        s_axi.awaddr = 8'h34; s_axi.wdata = 32'ha5a50001; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
        n = 0;
        while (!s_axi.awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_timeout("bp_first_aw");
        @(posedge clk); #1;
        s_axi.awaddr = 8'h38; s_axi.wdata = 32'ha5a50002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {s_axi.bvalid, s_axi.bresp, s_axi.awready}, 4'b1000);
        end
        s_axi.bready = 1'b1;
        n = 0;
        while (!s_axi.awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_timeout("bp_second_aw");
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axi.bvalid && n < 50) begin @(negedge clk); n++; end
        check("bp_second_bresp", {s_axi.bvalid, s_axi.bresp}, 3'b100);
        @(posedge clk); #1;
        s_axi.bready = 1'b0;
        $display("wr addr=34/38 back-pressured pair complete");
        axi_read(8'h34, d, r);
        check("bp_din1", d, 32'ha5a50001);
        axi_read(8'h38, d, r);
        check("bp_din2", d, 32'ha5a50002);

        // Core error in WAIT_RDY, then sticky clear
        key_inp_rdy = 1'b0;
        inject_err  = 1'b1;
        axi_write(8'h00, 32'h01, r);
        wait_idle(st);
        check("err_status", st, 32'h04);
        inject_err = 1'b0;
        axi_read(8'h40, d, r);
        check("err_dout0", d, 32'h3925841d);
        axi_write(8'h00, 32'h20, r);
        axi_read(8'h04, d, r);
        check("err_cleared", d, 32'h00);

        // Reset while waiting for the core enable
        pt_in_en = 1'b0;
        p0 = pt_pulses;
        axi_write(8'h00, 32'h1D, r);
        axi_read(8'h04, d, r);
        check("rst_busy", d, 32'h01);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_axi", {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bresp,
                                s_axi.arready, s_axi.rvalid, s_axi.rresp, s_axi.rdata}, '0);
        check("rst_async_core", {pt_valid, ct_valid, key_len, short_key, pt_encr}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pt_in_en = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_launch", pt_pulses, p0);
        axi_read(8'h04, d, r);
        check("rst_status", d, 32'h00);
        axi_read(8'h10, d, r);
        check("rst_key0", d, 32'h00);
        axi_read(8'h40, d, r);
        check("rst_dout0", d, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
